// File: rtl/logger_axil_pkg.sv
// Shared response codes, FSM state types and the byte-lane merge helper
// for the logger AXI4-Lite register file.
package logger_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/logger_axil_regs.sv
// AXI4-Lite slave holding NUM_REGS 32-bit control registers for the logger
// datapath; independent write and read FSMs, contents and write pulses exported.
module logger_axil_regs
   import logger_axil_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [ADDR_WIDTH-1:0]          s_awaddr,
   input  logic [2:0]                     s_awprot,
   input  logic                           s_awvalid,
   output logic                           s_awready,
   input  logic [DATA_WIDTH-1:0]          s_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
   input  logic                           s_wvalid,
   output logic                           s_wready,
   output logic [1:0]                     s_bresp,
   output logic                           s_bvalid,
   input  logic                           s_bready,
   input  logic [ADDR_WIDTH-1:0]          s_araddr,
   input  logic [2:0]                     s_arprot,
   input  logic                           s_arvalid,
   output logic                           s_arready,
   output logic [DATA_WIDTH-1:0]          s_rdata,
   output logic [1:0]                     s_rresp,
   output logic                           s_rvalid,
   input  logic                           s_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int IDXW = ADDR_WIDTH - 2;
   localparam int SW   = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]   r_wr_pulse;

   wstate_e               r_wstate;
   logic                  r_aw_held;
   logic                  r_w_held;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [SW-1:0]         r_wstrb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   rstate_e               r_rstate;
   logic                  r_rvalid;
   logic [1:0]            r_rresp;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_commit;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [SW-1:0]         w_wr_strb;
   logic [IDXW-1:0]       w_wr_idx;
   logic                  w_wr_in;
   logic [IDXW-1:0]       w_rd_idx;
   logic                  w_rd_in;
   logic [DATA_WIDTH-1:0] w_rd_val;

   // protection bits carry no meaning for this register file
   logic                  w_unused_prot;
   assign w_unused_prot = ^{s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0]};

   assign s_awready = (r_wstate == W_IDLE) && !r_aw_held;
   assign s_wready  = (r_wstate == W_IDLE) && !r_w_held;
   assign s_arready = (r_rstate == R_IDLE);
   assign s_bvalid  = r_bvalid;
   assign s_bresp   = r_bresp;
   assign s_rvalid  = r_rvalid;
   assign s_rresp   = r_rresp;
   assign s_rdata   = r_rdata;
   assign reg_wr_pulse = r_wr_pulse;

   assign w_aw_hs = s_awvalid && s_awready;
   assign w_w_hs  = s_wvalid && s_wready;
   assign w_ar_hs = s_arvalid && s_arready;

   // a held beat and a live handshake are interchangeable for committing
   assign w_commit  = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
   assign w_wr_addr = r_aw_held ? r_awaddr : s_awaddr;
   assign w_wr_data = r_w_held ? r_wdata : s_wdata;
   assign w_wr_strb = r_w_held ? r_wstrb : s_wstrb;
   assign w_wr_idx  = w_wr_addr[ADDR_WIDTH-1:2];
   assign w_wr_in   = 32'(w_wr_idx) < 32'(NUM_REGS);

   assign w_rd_idx  = s_araddr[ADDR_WIDTH-1:2];
   assign w_rd_in   = 32'(w_rd_idx) < 32'(NUM_REGS);

   always_comb begin
      w_rd_val = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (w_rd_idx == IDXW'(i)) w_rd_val = r_regs[i];
      end
   end

   always_comb begin
      reg_q = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wstate   <= W_IDLE;
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= '0;
         r_wr_pulse <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_wr_pulse <= '0;
         case (r_wstate)
            W_IDLE: begin
               if (w_commit) begin
                  for (int unsigned i = 0; i < NUM_REGS; i++) begin
                     if (w_wr_in && (w_wr_idx == IDXW'(i))) begin
                        r_regs[i]     <= byte_merge(r_regs[i], w_wr_data, w_wr_strb);
                        r_wr_pulse[i] <= |w_wr_strb;
                     end
                  end
                  r_bresp   <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
                  r_bvalid  <= 1'b1;
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_wstate  <= W_RESP;
               end else begin
                  if (w_aw_hs) begin
                     r_aw_held <= 1'b1;
                     r_awaddr  <= s_awaddr;
                  end
                  if (w_w_hs) begin
                     r_w_held <= 1'b1;
                     r_wdata  <= s_wdata;
                     r_wstrb  <= s_wstrb;
                  end
               end
            end
            W_RESP: begin
               if (s_bready) begin
                  r_bvalid <= 1'b0;
                  r_wstate <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rstate <= R_IDLE;
         r_rvalid <= 1'b0;
         r_rresp  <= '0;
         r_rdata  <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rdata  <= w_rd_in ? w_rd_val : '0;
                  r_rresp  <= w_rd_in ? RESP_OKAY : RESP_SLVERR;
                  r_rvalid <= 1'b1;
                  r_rstate <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_rready) begin
                  r_rvalid <= 1'b0;
                  r_rstate <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   a_b_stable: assert property (@(posedge clock) disable iff (reset)
      (s_bvalid && !s_bready) |=> (s_bvalid && $stable(s_bresp)));
   a_r_stable: assert property (@(posedge clock) disable iff (reset)
      (s_rvalid && !s_rready) |=> (s_rvalid && $stable(s_rdata) && $stable(s_rresp)));

endmodule

// File: tb/tb_logger_axil_regs.sv
// Directed bench for logger_axil_regs: vector table of write/read transactions
// plus hand-written sequences for W-before-AW, back-pressure and mid-response reset.
module tb_logger_axil_regs;

   logic         clock = 1'b0;
   logic         reset;
   logic [4:0]   s_awaddr;
   logic [2:0]   s_awprot;
   logic         s_awvalid;
   logic         s_awready;
   logic [31:0]  s_wdata;
   logic [3:0]   s_wstrb;
   logic         s_wvalid;
   logic         s_wready;
   logic [1:0]   s_bresp;
   logic         s_bvalid;
   logic         s_bready;
   logic [4:0]   s_araddr;
   logic [2:0]   s_arprot;
   logic         s_arvalid;
   logic         s_arready;
   logic [31:0]  s_rdata;
   logic [1:0]   s_rresp;
   logic         s_rvalid;
   logic         s_rready;
   logic [127:0] reg_q;
   logic [3:0]   reg_wr_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   logger_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) dut (
      .clock(clock), .reset(reset),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   typedef struct {
      bit          is_wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] exp_data;
      logic [3:0]  pulse;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for handshake", name);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp, output logic [3:0] pls, output logic [3:0] pls_after);
      bit ga, gw, seen;
      resp = 2'b11; pls = 4'hx; pls_after = 4'hx;
      @(posedge clock); #1;
      s_awaddr = a; s_awvalid = 1'b1;
      s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
      for (int c = 0; c < 20 && (s_awvalid || s_wvalid); c++) begin
         @(negedge clock);
         ga = s_awvalid && s_awready;
         gw = s_wvalid && s_wready;
         @(posedge clock); #1;
         if (ga) s_awvalid = 1'b0;
         if (gw) s_wvalid = 1'b0;
      end
      if (s_awvalid || s_wvalid) begin
         timeout("write addr/data");
         s_awvalid = 1'b0; s_wvalid = 1'b0;
         return;
      end
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (s_bvalid) begin
            seen = 1'b1; resp = s_bresp; pls = reg_wr_pulse;
            break;
         end
      end
      if (!seen) begin
         timeout("write bvalid");
         return;
      end
      @(posedge clock); #1;
      s_bready = 1'b1;
      @(posedge clock); #1;
      s_bready = 1'b0;
      @(negedge clock);
      pls_after = reg_wr_pulse;
   endtask

   task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      bit ga, seen;
      d = 32'hx; resp = 2'b11;
      @(posedge clock); #1;
      s_araddr = a; s_arvalid = 1'b1;
      for (int c = 0; c < 20 && s_arvalid; c++) begin
         @(negedge clock);
         ga = s_arready;
         @(posedge clock); #1;
         if (ga) s_arvalid = 1'b0;
      end
      if (s_arvalid) begin
         timeout("read addr");
         s_arvalid = 1'b0;
         return;
      end
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (s_rvalid) begin
            seen = 1'b1; d = s_rdata; resp = s_rresp;
            break;
         end
      end
      if (!seen) begin
         timeout("read rvalid");
         return;
      end
      @(posedge clock); #1;
      s_rready = 1'b1;
      @(posedge clock); #1;
      s_rready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [3:0]  pls, pls_after;
      logic [31:0] rd;

      vecs[0]  = '{1'b1, 5'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0, 4'b0001};
      vecs[1]  = '{1'b1, 5'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0, 4'b0010};
      vecs[2]  = '{1'b1, 5'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0, 4'b0100};
      vecs[3]  = '{1'b1, 5'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0, 4'b1000};
      vecs[4]  = '{1'b0, 5'h00, 32'h0, 4'h0, 2'b00, 32'h0000_0001, 4'b0};
      vecs[5]  = '{1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 32'h0000_0002, 4'b0};
      vecs[6]  = '{1'b0, 5'h08, 32'h0, 4'h0, 2'b00, 32'h0000_0003, 4'b0};
      vecs[7]  = '{1'b0, 5'h0C, 32'h0, 4'h0, 2'b00, 32'h0000_0004, 4'b0};
      vecs[8]  = '{1'b1, 5'h04, 32'h1122_3344, 4'hF, 2'b00, 32'h0, 4'b0010};
      vecs[9]  = '{1'b1, 5'h04, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0, 4'b0010};
      vecs[10] = '{1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 32'h11BB_33DD, 4'b0};
      vecs[11] = '{1'b1, 5'h04, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0, 4'b0000};
      vecs[12] = '{1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 32'h11BB_33DD, 4'b0};
      vecs[13] = '{1'b0, 5'h07, 32'h0, 4'h0, 2'b00, 32'h11BB_33DD, 4'b0};
      vecs[14] = '{1'b1, 5'h10, 32'h1234_5678, 4'hF, 2'b10, 32'h0, 4'b0000};
      vecs[15] = '{1'b0, 5'h10, 32'h0, 4'h0, 2'b10, 32'h0000_0000, 4'b0};
      vecs[16] = '{1'b0, 5'h00, 32'h0, 4'h0, 2'b00, 32'h0000_0001, 4'b0};
      vecs[17] = '{1'b0, 5'h08, 32'h0, 4'h0, 2'b00, 32'h0000_0003, 4'b0};
      vecs[18] = '{1'b0, 5'h0C, 32'h0, 4'h0, 2'b00, 32'h0000_0004, 4'b0};
      vecs[19] = '{1'b0, 5'h1C, 32'h0, 4'h0, 2'b10, 32'h0000_0000, 4'b0};

      reset = 1'b1;
      s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
      s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("reset reg_q", reg_q, 128'h0);
      check("reset valids/pulse", {s_bvalid, s_rvalid, reg_wr_pulse}, 6'b0);
      check("reset readies", {s_awready, s_wready, s_arready}, 3'b111);
      check("reset rdata/resp", {s_rdata, s_rresp, s_bresp}, 36'h0);

      for (int i = 0; i < 20; i++) begin
         if (vecs[i].is_wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pls, pls_after);
            check($sformatf("vec%0d bresp", i), resp, vecs[i].resp);
            check($sformatf("vec%0d pulse", i), pls, vecs[i].pulse);
            check($sformatf("vec%0d pulse_after", i), pls_after, 4'b0);
         end else begin
            do_read(vecs[i].addr, rd, resp);
            check($sformatf("vec%0d rresp", i), resp, vecs[i].resp);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_data);
         end
      end
      check("oor untouched reg_q", reg_q, {32'h4, 32'h3, 32'h11BB_33DD, 32'h1});

      // W three cycles ahead of AW
      @(posedge clock); #1;
      s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1; s_awaddr = 5'h08;
      @(negedge clock);
      check("early W wready", s_wready, 1'b1);
      @(posedge clock); #1;
      s_wvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check($sformatf("early W hold%0d wready/bvalid/awready", k), {s_wready, s_bvalid, s_awready}, 3'b001);
         @(posedge clock); #1;
      end
      s_awvalid = 1'b1;
      @(negedge clock);
      check("late AW awready", s_awready, 1'b1);
      @(posedge clock); #1;
      s_awvalid = 1'b0;
      @(negedge clock);
      check("late AW bvalid/awready/wready", {s_bvalid, s_awready, s_wready}, 3'b100);
      check("late AW bresp", s_bresp, 2'b00);
      check("late AW reg2", reg_q[95:64], 32'hDEAD_BEEF);
      @(posedge clock); #1 s_bready = 1'b1;
      @(posedge clock); #1 s_bready = 1'b0;

      // write and read of the same register in one cycle, then back-pressure
      s_awaddr = 5'h0C; s_wdata = 32'hCAFE_0001; s_wstrb = 4'hF; s_araddr = 5'h0C;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      @(negedge clock);
      check("stall start readies", {s_awready, s_wready, s_arready}, 3'b111);
      @(posedge clock); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check($sformatf("stall%0d flags", k), {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, 5'b11000);
         check($sformatf("stall%0d rdata", k), s_rdata, 32'h0000_0004);
         check($sformatf("stall%0d resps", k), {s_bresp, s_rresp}, 4'b0);
         @(posedge clock); #1;
      end
      check("same-reg write landed", reg_q[127:96], 32'hCAFE_0001);
      s_bready = 1'b1; s_rready = 1'b1;
      @(posedge clock); #1;
      s_bready = 1'b0; s_rready = 1'b0;
      @(negedge clock);
      check("stall recover flags", {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, 5'b00111);

      // reset while a write response is pending
      @(posedge clock); #1;
      s_awaddr = 5'h00; s_wdata = 32'h55; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
      @(posedge clock); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      @(negedge clock);
      check("pre-reset bvalid", s_bvalid, 1'b1);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      check("post-reset bvalid", s_bvalid, 1'b0);
      check("post-reset reg_q", reg_q, 128'h0);
      for (int r = 0; r < 4; r++) begin
         do_read(5'(r * 4), rd, resp);
         check($sformatf("post-reset read%0d", r), {resp, rd}, 34'h0);
      end
      do_write(5'h08, 32'h0000_0077, 4'hF, resp, pls, pls_after);
      check("post-reset write bresp", resp, 2'b00);
      check("post-reset write pulse", pls, 4'b0100);
      do_read(5'h08, rd, resp);
      check("post-reset read back", {resp, rd}, {2'b00, 32'h0000_0077});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
